// File: rtl/if_id_queue.sv
// if_id_queue: instruction queue between fetch and decode, replacing the IF/ID register.
//
// Fetch pushes {instructionf, pc_plus_4f} when validf is high and the queue is not full.
// Decode sees the oldest entry on instrd/pc_plus_4d/validd and pops it when stalld is low.
// A taken branch in decode (flushd) discards every queued and incoming word.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   instructionf           instruction word from fetch
//   pc_plus_4f             PC+4 of that instruction
//   validf                 fetch presents a word (push request)
//   stalld                 decode cannot consume (pop inhibit)
//   flushd                 discard all queued and incoming words
//   instrd, pc_plus_4d     head entry (NOP_WORD / 0 when empty)
//   validd                 head entry is valid
//   stallf_q               queue full, fetch must hold
//   count                  current occupancy
//
// Optional feature macro: IFQ_BYPASS_EN
//   When defined, an incoming word on an empty queue is forwarded to decode in the same
//   cycle; if decode consumes it, it is never written into storage.

module if_id_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instructionf,
    input  logic [31:0]              pc_plus_4f,
    input  logic                     validf,
    input  logic                     stalld,
    input  logic                     flushd,
    output logic [31:0]              instrd,
    output logic [31:0]              pc_plus_4d,
    output logic                     validd,
    output logic                     stallf_q,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [63:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic [63:0] head;

    // Full is judged on registered occupancy only, so stallf_q never depends on inputs.
    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & validf & ~flushd;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode consumes immediately is never stored.
    assign push = validf & ~full & ~(bypass & ~stalld);
    assign pop  = ~empty & ~stalld;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flushd) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + PtrW'(1);
            end
            if (pop) begin
                rp_d = rp_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not cleared by reset or flush; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && !flushd && push) begin
            mem_q[wp_q] <= {instructionf, pc_plus_4f};
        end
    end

    assign head = mem_q[rp_q];

    always_comb begin
        validd     = ~empty | bypass;
        instrd     = NOP_WORD;
        pc_plus_4d = 32'h0000_0000;
        if (bypass) begin
            instrd     = instructionf;
            pc_plus_4d = pc_plus_4f;
        end else if (!empty) begin
            instrd     = head[63:32];
            pc_plus_4d = head[31:0];
        end
    end

    assign stallf_q = full;
    assign count    = cnt_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instructionf = '0;
    logic [31:0] pc_plus_4f = '0;
    logic        validf = 1'b0;
    logic        stalld = 1'b0;
    logic        flushd = 1'b0;
    logic [31:0] instrd;
    logic [31:0] pc_plus_4d;
    logic        validd;
    logic        stallf_q;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted but not yet consumed, oldest first.
    logic [63:0] exp_q[$];
    bit          byp_pending = 1'b0;

    if_id_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .instructionf (instructionf),
        .pc_plus_4f   (pc_plus_4f),
        .validf       (validf),
        .stalld       (stalld),
        .flushd       (flushd),
        .instrd       (instrd),
        .pc_plus_4d   (pc_plus_4d),
        .validd       (validd),
        .stallf_q     (stallf_q),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle after inputs settle and checks against the model.
    always begin
        int unsigned stored;
        bit          exp_valid;
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (!reset) begin
            stored    = exp_q.size() - (byp_pending ? 1 : 0);
            exp_valid = (exp_q.size() != 0);
            check("count", 64'(count), 64'(stored));
            check("stallf_q", 64'(stallf_q), 64'(stored == DEPTH));
            check("validd", 64'(validd), 64'(exp_valid));
            if (exp_valid) begin
                e = exp_q[0];
                check("head", {instrd, pc_plus_4d}, e);
                if (!stalld) void'(exp_q.pop_front());
            end else begin
                check("empty_head", {instrd, pc_plus_4d}, {NOP, 32'h0});
            end
        end
    end

    // One clock of stimulus; the model absorbs push/flush/reset at the edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic stl, input logic fl, input logic rs);
        bit push_ok;
        @(negedge clk);
        validf       = v;
        instructionf = ins;
        pc_plus_4f   = pc;
        stalld       = stl;
        flushd       = fl;
        reset        = rs;
        push_ok      = v && !rs && !fl && (exp_q.size() != DEPTH);
        byp_pending  = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (v && !rs && !fl && exp_q.size() == 0) begin
            exp_q.push_back({ins, pc});
            byp_pending = 1'b1;
        end
`endif
        @(posedge clk);
        if (rs || fl) exp_q.delete();
        else if (push_ok && !byp_pending) exp_q.push_back({ins, pc});
        byp_pending = 1'b0;
    endtask

    logic [31:0] fill_ins [4] = '{32'h8C010004, 32'h8C020004, 32'h8C030008, 32'h8C04000C};

    initial begin
        // Reset then idle.
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Fill and hold, then a dropped fifth push.
        for (int i = 0; i < 4; i++)
            drive(1'b1, fill_ins[i], 32'h00400004 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hDEADBEEF, 32'h00400014, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        // Drain in order.
        for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 3 * DEPTH; i++)
            drive(1'b1, 32'h24000000 + 32'(i), 32'h00401000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h3C000000 + 32'(i), 32'h00402000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hBADC0DE0, 32'h00402010, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush at count 3 with an incoming word, then a normal push.
        drive(1'b1, 32'hBADC0DE1, 32'h00402014, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h8C050010, 32'h00403004, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Empty queue, single push with decode ready (bypass case when enabled).
        drive(1'b1, 32'h20020005, 32'h00404004, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 59) == 0));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
